// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin register-file writeback arbiter with busy scoreboard (optional forwarding: RF_WB_BYPASS_EN)
module rf_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_data,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    input  logic [AW-1:0]      rs,
    input  logic [AW-1:0]      rt,
    output logic               rs_busy,
    output logic               rt_busy,
    output logic [31:0]        busy,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd
`ifdef RF_WB_BYPASS_EN
    ,
    output logic               rs_fwd,
    output logic               rt_fwd,
    output logic [DW-1:0]      rs_fwd_data,
    output logic [DW-1:0]      rt_fwd_data
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic          xfer;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;
    logic [31:0]   busy_nxt;
    int            idx;

    // Scan from the highest offset down so the last hit is the first valid at/after ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any && rst_n)
            req_ready = N_REQ'(1) << gnt_idx;
    end

    assign xfer     = |(req_valid & req_ready);
    assign gnt_addr = req_addr[gnt_idx*AW +: AW];
    assign gnt_data = req_data[gnt_idx*DW +: DW];

    // Clear for the write leaving the output stage first, so a same-edge reservation wins.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_wa] = 1'b0;
        if (rsv_valid && (rsv_addr != '0))
            busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr   <= '0;
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
            busy  <= '0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= xfer && (gnt_addr != '0);
            if (xfer) begin
                ptr <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                if (gnt_addr != '0) begin
                    rf_wa <= gnt_addr;
                    rf_wd <= gnt_data;
                end
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign rs_fwd      = rf_we && (rf_wa == rs) && (rs != '0);
    assign rt_fwd      = rf_we && (rf_wa == rt) && (rt != '0);
    assign rs_fwd_data = rf_wd;
    assign rt_fwd_data = rf_wd;
    assign rs_busy     = busy[rs] && !rs_fwd;
    assign rt_busy     = busy[rt] && !rt_fwd;
`else
    assign rs_busy     = busy[rs];
    assign rt_busy     = busy[rt];
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a behavioural model
module tb_rf_wb_arbiter;
    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            rsv_valid = 1'b0;
    logic [AW-1:0]   rsv_addr = '0, rs = '0, rt = '0;
    logic            rs_busy, rt_busy;
    logic [31:0]     busy;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [DW-1:0]   rf_wd;
`ifdef RF_WB_BYPASS_EN
    logic            rs_fwd, rt_fwd;
    logic [DW-1:0]   rs_fwd_data, rt_fwd_data;
`endif

    rf_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .busy(busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
`ifdef RF_WB_BYPASS_EN
        , .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
        .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;

    // stimulus state
    bit            vld[N];
    logic [AW-1:0] adr[N];
    logic [DW-1:0] dat[N];
    bit            gr[N];
    bit            rsv_v;
    logic [AW-1:0] rsv_a, rs_i, rt_i;
    logic [N-1:0]  last_ready;

    // reference model state
    int            ptr_m;
    bit [31:0]     bsy_m;
    bit            we_m;
    logic [AW-1:0] wa_m;
    logic [DW-1:0] wd_m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write presented on the port must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rf_write: got unexpected write wa=%0h wd=%0h expected none at %0t",
                             rf_wa, rf_wd, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("rf_wa", 64'(rf_wa), 64'(e.wa));
                    chk("rf_wd", 64'(rf_wd), 64'(e.wd));
                end
            end else if (rf_we !== 1'b0) begin
                chk("rf_we_known", 64'(rf_we), 64'd0);
            end
        end
    end

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = vld[i];
            req_addr[i*AW +: AW]   = adr[i];
            req_data[i*DW +: DW]   = dat[i];
        end
        rsv_valid = rsv_v;
        rsv_addr  = rsv_a;
        rs        = rs_i;
        rt        = rt_i;
    endtask

    task automatic step();
        int        g;
        int        id;
        bit [31:0] nb;
        bit        fwd_s, fwd_t;
        logic [N-1:0] exp_rdy;
        apply();
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            id = (ptr_m + k) % N;
            if (g < 0 && vld[id]) g = id;
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        last_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        fwd_s = 1'b0;
        fwd_t = 1'b0;
`ifdef RF_WB_BYPASS_EN
        fwd_s = we_m && (wa_m == rs_i) && (rs_i != 0);
        fwd_t = we_m && (wa_m == rt_i) && (rt_i != 0);
        chk("rs_fwd", 64'(rs_fwd), 64'(fwd_s));
        chk("rt_fwd", 64'(rt_fwd), 64'(fwd_t));
        if (fwd_s) chk("rs_fwd_data", 64'(rs_fwd_data), 64'(wd_m));
        if (fwd_t) chk("rt_fwd_data", 64'(rt_fwd_data), 64'(wd_m));
`endif
        chk("rs_busy", 64'(rs_busy), 64'(bsy_m[rs_i] && !fwd_s));
        chk("rt_busy", 64'(rt_busy), 64'(bsy_m[rt_i] && !fwd_t));
        nb = bsy_m;
        if (we_m) nb[wa_m] = 1'b0;
        if (rsv_v && rsv_a != 0) nb[rsv_a] = 1'b1;
        for (int i = 0; i < N; i++) gr[i] = (i == g);
        if (g >= 0 && adr[g] != 0) exp_q.push_back(wr_t'{wa: adr[g], wd: dat[g]});
        @(posedge clk);
        bsy_m = nb;
        we_m  = 1'b0;
        if (g >= 0) begin
            ptr_m = (g + 1) % N;
            if (adr[g] != 0) begin
                we_m = 1'b1;
                wa_m = adr[g];
                wd_m = dat[g];
            end
        end
        @(negedge clk);
        chk("rf_we", 64'(rf_we), 64'(we_m));
        chk("busy", 64'(busy), 64'(bsy_m));
    endtask

    task automatic idle();
        for (int i = 0; i < N; i++) vld[i] = 1'b0;
        rsv_v = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b1;
            adr[i] = AW'(i + 1);
            dat[i] = 32'hA + DW'(i);
            gr[i]  = 1'b0;
        end
        rsv_v = 1'b0; rsv_a = '0; rs_i = '0; rt_i = '0;
        // reset with every requester asserting
        rst_n = 1'b0;
        apply();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_wa", 64'(rf_wa), 64'd0);
        chk("reset_rf_wd", 64'(rf_wd), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        ptr_m = 0; bsy_m = '0; we_m = 1'b0; wa_m = '0; wd_m = '0;
        mon_en = 1'b1;

        // round robin with all three continuously valid
        for (int j = 0; j < 4; j++) begin
            step();
            chk("rr_grant", 64'(last_ready), 64'(N'(1) << (j % N)));
        end
        idle();
        step();

        // reservation, write, clear
        rsv_v = 1'b1; rsv_a = 5'd5;
        step();
        rsv_v = 1'b0; rs_i = 5'd5;
        step();
        chk("rsv5_rs_busy", 64'(rs_busy), 64'd1);
        vld[1] = 1'b1; adr[1] = 5'd5; dat[1] = 32'hDEADBEEF;
        step();
        chk("lat_rf_we", 64'(rf_we), 64'd1);
        chk("lat_rf_wa", 64'(rf_wa), 64'd5);
        chk("lat_rf_wd", 64'(rf_wd), 64'hDEADBEEF);
        vld[1] = 1'b0;
        step();
        chk("busy5_clear", 64'(busy[5]), 64'd0);

        // address 0 from requester 2
        vld[2] = 1'b1; adr[2] = '0; dat[2] = 32'h1234;
        step();
        chk("r0_ready", 64'(last_ready), 64'b100);
        chk("r0_rf_we", 64'(rf_we), 64'd0);
        for (int i = 0; i < N; i++) begin vld[i] = 1'b1; adr[i] = AW'(i + 1); end
        step();
        chk("r0_ptr_wrap", 64'(last_ready), 64'b001);
        idle();
        step();

        // reserve-during-write collision on r7
        rsv_v = 1'b1; rsv_a = 5'd7;
        step();
        rsv_v = 1'b0; vld[0] = 1'b1; adr[0] = 5'd7; dat[0] = 32'h77;
        step();
        vld[0] = 1'b0; rsv_v = 1'b1; rsv_a = 5'd7;
        step();
        chk("collide_busy7", 64'(busy[7]), 64'd1);
        idle();

        // forwarding window on r9
        rsv_v = 1'b1; rsv_a = 5'd9;
        step();
        rsv_v = 1'b0; vld[0] = 1'b1; adr[0] = 5'd9; dat[0] = 32'h55;
        step();
        vld[0] = 1'b0; rs_i = 5'd9;
        apply();
        #1;
`ifdef RF_WB_BYPASS_EN
        chk("byp_rs_fwd", 64'(rs_fwd), 64'd1);
        chk("byp_rs_fwd_data", 64'(rs_fwd_data), 64'h55);
        chk("byp_rs_busy", 64'(rs_busy), 64'd0);
`else
        chk("nobyp_rs_busy", 64'(rs_busy), 64'd1);
`endif
        step();

        // randomized traffic with hold-until-ready
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] || gr[i]) begin
                    vld[i] = ($urandom_range(0, 3) != 0);
                    adr[i] = AW'($urandom_range(0, 9));
                    dat[i] = $urandom;
                end
            end
            rsv_v = ($urandom_range(0, 2) == 0);
            rsv_a = AW'($urandom_range(0, 9));
            rs_i  = AW'($urandom_range(0, 9));
            rt_i  = AW'($urandom_range(0, 9));
            step();
        end
        idle();
        step();
        step();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
